// File: rtl/run_controller.sv
// Host-side job controller: streams a byte image into the core's data memory,
// then releases the core, issues a start request and times the run.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the first beat of a new image
// S_LOAD    | accepting image beats, writing them to data memory
// S_RELEASE | core reset dropped, last beat's write in flight
// S_START   | one-cycle start request to the core
// S_RUN     | counting cycles until done or timeout
// S_REPORT  | one-cycle completion pulse, core held in reset again
module run_controller #(
    parameter int DATA_MEMORY_SIZE = 256,
    parameter int ADDR_W           = 8,
    parameter int CNT_W            = 16,
    parameter int TIMEOUT          = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              req,
    input  logic              done,
    output logic              busy,
    output logic              run_done,
    output logic              timed_out,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DATA_MEMORY_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RELEASE, S_START, S_RUN, S_REPORT
    } state_t;

    state_t            state, state_nx;
    logic [PTR_W-1:0]  ptr, ptr_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        wdata_nx;
    logic              to_nx, ovf_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              accept;

    assign in_ready = (state == S_IDLE) || (state == S_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        we_nx    = 1'b0;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        to_nx    = timed_out;
        ovf_nx   = overflow;
        cnt_nx   = cycle_count;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    ovf_nx   = 1'b0;
                    to_nx    = 1'b0;
                    cnt_nx   = '0;
                    we_nx    = 1'b1;
                    addr_nx  = '0;
                    wdata_nx = in_data;
                    ptr_nx   = PTR_W'(1);
                    state_nx = in_last ? S_RELEASE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // pointer saturates at the memory size; excess beats are dropped
                    if (ptr == PTR_FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        we_nx    = 1'b1;
                        addr_nx  = ptr[ADDR_W-1:0];
                        wdata_nx = in_data;
                        ptr_nx   = ptr + PTR_W'(1);
                    end
                    if (in_last) state_nx = S_RELEASE;
                end
            end
            S_RELEASE: state_nx = S_START;
            S_START: begin
                cnt_nx   = '0;
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (done) begin
                    to_nx    = 1'b0;
                    state_nx = S_REPORT;
                end else if (cycle_count == CNT_LAST) begin
                    cnt_nx   = CNT_TO;
                    to_nx    = 1'b1;
                    state_nx = S_REPORT;
                end else begin
                    cnt_nx = cycle_count + CNT_W'(1);
                end
            end
            S_REPORT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // control outputs are registered decodes of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_reset  <= 1'b1;
            req         <= 1'b0;
            run_done    <= 1'b0;
            busy        <= 1'b0;
            timed_out   <= 1'b0;
            overflow    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            mem_we      <= we_nx;
            mem_addr    <= addr_nx;
            mem_wdata   <= wdata_nx;
            core_reset  <= (state_nx == S_IDLE) || (state_nx == S_LOAD) || (state_nx == S_REPORT);
            req         <= (state_nx == S_START);
            run_done    <= (state_nx == S_REPORT);
            busy        <= (state_nx != S_IDLE);
            timed_out   <= to_nx;
            overflow    <= ovf_nx;
            cycle_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: an edge-counting job model checked every cycle,
// plus directed jobs with hand-computed expectations.
module tb_run_controller;

    localparam int SIZE = 256;
    localparam int AW   = 8;
    localparam int CW   = 16;
    localparam int TO   = 20;

    logic          clk, reset, in_valid, in_ready, in_last, mem_we, core_reset;
    logic          req, done, busy, run_done, timed_out, overflow;
    logic [7:0]    in_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    run_controller #(.DATA_MEMORY_SIZE(SIZE), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_reset(core_reset), .req(req), .done(done),
        .busy(busy), .run_done(run_done), .timed_out(timed_out), .overflow(overflow),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job model: tracks accepted beats and counts edges since the last beat.
    bit m_acc, m_running, m_report;
    int m_n, m_last_edge, cyc;
    bit e_we, e_req, e_rd, e_cr, e_busy, e_to, e_ovf;
    int e_addr, e_wdata, e_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_acc = 1; m_n = 0; m_running = 0; m_report = 0; m_last_edge = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_req = 0; e_rd = 0; e_cr = 1;
            e_busy = 0; e_to = 0; e_ovf = 0; e_cnt = 0;
        end else begin
            cyc++;
            e_we = 0; e_req = 0; e_rd = 0;
            if (m_report) begin
                m_report = 0; m_acc = 1; m_n = 0;
            end else if (m_acc) begin
                if (in_valid) begin
                    if (m_n == 0) begin e_ovf = 0; e_to = 0; e_cnt = 0; end
                    if (m_n < SIZE) begin e_we = 1; e_addr = m_n; e_wdata = int'(in_data); end
                    else e_ovf = 1;
                    m_n++;
                    if (in_last) begin m_acc = 0; m_last_edge = cyc; end
                end
            end else if (m_running) begin
                if (done) begin
                    m_running = 0; m_report = 1; e_rd = 1; e_to = 0;
                end else if (e_cnt == TO - 1) begin
                    e_cnt = TO; e_to = 1; m_running = 0; m_report = 1; e_rd = 1;
                end else begin
                    e_cnt++;
                end
            end else begin
                if (cyc - m_last_edge == 1) e_req = 1;
                else if (cyc - m_last_edge == 2) begin e_cnt = 0; m_running = 1; end
            end
            e_cr   = m_acc || m_report;
            e_busy = !(m_acc && m_n == 0);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_acc));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
            chk("mem_addr", 32'(mem_addr), e_addr);
            chk("mem_wdata", 32'(mem_wdata), e_wdata);
        end
        chk("core_reset", 32'(core_reset), 32'(e_cr));
        chk("req", 32'(req), 32'(e_req));
        chk("run_done", 32'(run_done), 32'(e_rd));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("timed_out", 32'(timed_out), 32'(e_to));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("cycle_count", 32'(cycle_count), e_cnt);
    end

    int wq_a[$];
    int wq_d[$];
    int rd_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            wq_a.push_back(int'(mem_addr));
            wq_d.push_back(int'(mem_wdata));
        end
        if (run_done) rd_cnt++;
    end

    task automatic send(input logic [7:0] d, input logic l);
        int i = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && i < 50) begin @(negedge clk); i++; end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_req();
        int i = 0;
        while (req !== 1'b1 && i < 200) begin @(negedge clk); i++; end
        chk("req_wait", 32'(req), 32'd1);
    endtask

    task automatic wait_rd(output int n);
        n = 0;
        while (run_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("run_done_wait", 32'(run_done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd0;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // four-byte image, done after ten RUN cycles
        wq_a.delete(); wq_d.delete();
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        wait_req();
        repeat (11) @(negedge clk);
        done = 1'b1;
        wait_rd(n);
        done = 1'b0;
        chk("t1_nwrites", wq_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", wq_a[i], i);
            chk("t1_data", wq_d[i], 32'h11 * (i + 1));
        end
        chk("t1_count", 32'(cycle_count), 10);
        chk("t1_timed_out", 32'(timed_out), 0);
        @(negedge clk);

        // single beat, done already high
        done = 1'b1;
        send(8'h5A, 1'b1);
        wait_rd(n);
        done = 1'b0;
        chk("t2_count", 32'(cycle_count), 0);
        @(negedge clk);

        // 258 beats into a 256-byte memory
        wq_a.delete(); wq_d.delete();
        for (int i = 0; i < 258; i++) send(8'(i), i == 257);
        wait_req();
        repeat (3) @(negedge clk);
        done = 1'b1;
        wait_rd(n);
        done = 1'b0;
        chk("t3_nwrites", wq_a.size(), 256);
        chk("t3_first_addr", wq_a[0], 0);
        chk("t3_last_addr", wq_a[255], 255);
        chk("t3_last_data", wq_d[255], 255);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_count", 32'(cycle_count), 2);
        @(negedge clk);

        // timeout with done held low
        send(8'h01, 1'b0); send(8'h02, 1'b1);
        wait_req();
        wait_rd(n);
        chk("t4_cycles_to_done", n, 21);
        chk("t4_count", 32'(cycle_count), 20);
        chk("t4_timed_out", 32'(timed_out), 1);
        chk("t4_core_reset", 32'(core_reset), 1);
        chk("t4_overflow", 32'(overflow), 0);
        @(negedge clk);

        // valid toggling every other cycle
        wq_a.delete(); wq_d.delete();
        for (int i = 0; i < 5; i++) begin
            send(8'hA0 + 8'(i), i == 4);
            if (i < 4) @(negedge clk);
        end
        wait_req();
        done = 1'b1;
        wait_rd(n);
        done = 1'b0;
        chk("t5_nwrites", wq_a.size(), 5);
        for (int i = 0; i < 5; i++) chk("t5_addr", wq_a[i], i);
        chk("t5_count", 32'(cycle_count), 0);
        @(negedge clk);

        // reset mid-run, then a fresh two-byte job
        send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b1);
        wait_req();
        repeat (4) @(negedge clk);
        rd0 = rd_cnt;
        #2 reset = 1'b0;
        #1;
        chk("t6_mem_we", 32'(mem_we), 0);
        chk("t6_mem_addr", 32'(mem_addr), 0);
        chk("t6_mem_wdata", 32'(mem_wdata), 0);
        chk("t6_core_reset", 32'(core_reset), 1);
        chk("t6_req", 32'(req), 0);
        chk("t6_run_done", 32'(run_done), 0);
        chk("t6_count", 32'(cycle_count), 0);
        chk("t6_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_no_run_done", rd_cnt, rd0);
        send(8'hC1, 1'b0); send(8'hC2, 1'b1);
        wait_req();
        repeat (3) @(negedge clk);
        done = 1'b1;
        wait_rd(n);
        done = 1'b0;
        chk("t6_new_count", 32'(cycle_count), 2);
        chk("t6_new_timed_out", 32'(timed_out), 0);
        chk("t6_new_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
